sram_rw_arbiter: RTL and testbench

- Shares one single-port 1RW OpenRAM SRAM macro (64-bit word, byte write mask) between two requesters, e.g. an I-side refill path and a D-side writeback path.
- Per-requester valid/ready request channel with round-robin arbitration.
- Drives the macro's chip-select, write-enable, mask, address and data pins.
- Returns read data through a one-entry response buffer per requester with backpressure.

---
 rtl/sram_rw_arbiter.sv | 96 +++++++++
 tb/tb_sram_rw_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: round-robin arbiter sharing one 1RW OpenRAM macro between two requesters.
// Define SRAM_ARB_PERF_EN to add saturating read/write/conflict performance counters.
module sram_rw_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WMASKS = 8
`ifdef SRAM_ARB_PERF_EN
  ,
  parameter int PERF_WIDTH = 16
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                req_valid_i,
  output logic [1:0]                req_ready_o,
  input  logic [1:0]                req_we_i,
  input  logic [2*NUM_WMASKS-1:0]   req_be_i,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata_i,
  output logic [1:0]                rsp_valid_o,
  input  logic [1:0]                rsp_ready_i,
  output logic [2*DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                      sram_csb_o,
  output logic                      sram_web_o,
  output logic [NUM_WMASKS-1:0]     sram_wmask_o,
  output logic                      sram_spare_wen_o,
  output logic [ADDR_WIDTH-1:0]     sram_addr_o,
  output logic [DATA_WIDTH-1:0]     sram_din_o,
  input  logic [DATA_WIDTH-1:0]     sram_dout_i
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]     perf_rd_o,
  output logic [PERF_WIDTH-1:0]     perf_wr_o,
  output logic [PERF_WIDTH-1:0]     perf_conflict_o
`endif
);
  logic                  r_rr_last, r_rd_pend, r_rd_id;
  logic [1:0]            w_cap, w_elig;
  logic                  w_any, w_gid, w_we, w_rd, w_wr;
  logic [NUM_WMASKS-1:0] w_be;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  // w_cap marks the requester whose read data is on sram_dout_i this cycle
  always_comb begin
    w_cap   = r_rd_pend ? (r_rd_id ? 2'b10 : 2'b01) : 2'b00;
    w_elig  = {2{rst_ni}} & req_valid_i & (req_we_i | (~w_cap & (~rsp_valid_o | rsp_ready_i)));
    w_any   = |w_elig;
    w_gid   = &w_elig ? ~r_rr_last : w_elig[1];
    w_we    = w_gid ? req_we_i[1] : req_we_i[0];
    w_be    = w_gid ? req_be_i[2*NUM_WMASKS-1:NUM_WMASKS] : req_be_i[NUM_WMASKS-1:0];
    w_addr  = w_gid ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
    w_wdata = w_gid ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
    w_rd    = w_any & ~w_we;
    w_wr    = w_any & w_we & (|w_be);
  end
  assign req_ready_o      = w_any ? (w_gid ? 2'b10 : 2'b01) : 2'b00;
  assign sram_csb_o       = ~(w_rd | w_wr);
  assign sram_web_o       = ~w_wr;
  assign sram_wmask_o     = w_wr ? w_be : (w_rd ? '1 : '0);
  assign sram_spare_wen_o = 1'b0;
  assign sram_addr_o      = (w_rd | w_wr) ? w_addr : '0;
  assign sram_din_o       = (w_rd | w_wr) ? w_wdata : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_last   <= 1'b1;
      r_rd_pend   <= 1'b0;
      r_rd_id     <= 1'b0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
    end else begin
      if (w_any) r_rr_last <= w_gid;
      r_rd_pend   <= w_rd;
      if (w_rd) r_rd_id <= w_gid;
      rsp_valid_o <= w_cap | (rsp_valid_o & ~rsp_ready_i);
      if (w_cap[0]) rsp_rdata_o[DATA_WIDTH-1:0] <= sram_dout_i;
      if (w_cap[1]) rsp_rdata_o[2*DATA_WIDTH-1:DATA_WIDTH] <= sram_dout_i;
    end
  end
`ifdef SRAM_ARB_PERF_EN
  logic [PERF_WIDTH-1:0] r_perf_rd, r_perf_wr, r_perf_cf;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_rd <= '0;
      r_perf_wr <= '0;
      r_perf_cf <= '0;
    end else begin
      if (w_rd && !(&r_perf_rd)) r_perf_rd <= r_perf_rd + PERF_WIDTH'(1);
      if (w_wr && !(&r_perf_wr)) r_perf_wr <= r_perf_wr + PERF_WIDTH'(1);
      if ((&req_valid_i) && w_any && !(&r_perf_cf)) r_perf_cf <= r_perf_cf + PERF_WIDTH'(1);
    end
  end
  assign perf_rd_o       = r_perf_rd;
  assign perf_wr_o       = r_perf_wr;
  assign perf_conflict_o = r_perf_cf;
`endif
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// tb_sram_rw_arbiter: directed bench with a read-data scoreboard and a behavioural 1RW SRAM.
// Perf counter checks are compiled in when SRAM_ARB_PERF_EN is defined.
module tb_sram_rw_arbiter;
  logic         clk_i, rst_ni;
  logic [1:0]   req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i;
  logic [15:0]  req_be_i;
  logic [17:0]  req_addr_i;
  logic [127:0] req_wdata_i, rsp_rdata_o;
  logic         sram_csb_o, sram_web_o, sram_spare_wen_o;
  logic [7:0]   sram_wmask_o;
  logic [8:0]   sram_addr_o;
  logic [63:0]  sram_din_o, sram_dout_i;
`ifdef SRAM_ARB_PERF_EN
  logic [15:0]  perf_rd_o, perf_wr_o, perf_conflict_o;
`endif
  logic [63:0]  mem [512];
  logic [63:0]  q0[$], q1[$];
  int           n_pass = 0, n_tot = 0;

  localparam logic [63:0] D0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D1 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D2 = 64'h00000000FFFFFFFF;

  sram_rw_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
    .sram_spare_wen_o(sram_spare_wen_o), .sram_addr_o(sram_addr_o),
    .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
`ifdef SRAM_ARB_PERF_EN
    , .perf_rd_o(perf_rd_o), .perf_wr_o(perf_wr_o), .perf_conflict_o(perf_conflict_o)
`endif
  );

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_wmask_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_din_o[b*8 +: 8];
      end else begin
        sram_dout_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic rq(input int i, input logic v, input logic we, input logic [7:0] be,
                    input logic [8:0] a, input logic [63:0] d);
    req_valid_i[i] = v;
    req_we_i[i] = we;
    req_be_i[i*8 +: 8] = be;
    req_addr_i[i*9 +: 9] = a;
    req_wdata_i[i*64 +: 64] = d;
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (rsp_valid_o[0] && rsp_ready_i[0]) begin
        if (q0.size() == 0) begin
          n_tot++;
          $display("FAIL rsp0_unexpected: got %0h expected none", rsp_rdata_o[63:0]);
        end else chk("rsp0_data", rsp_rdata_o[63:0], q0.pop_front());
      end
      if (rsp_valid_o[1] && rsp_ready_i[1]) begin
        if (q1.size() == 0) begin
          n_tot++;
          $display("FAIL rsp1_unexpected: got %0h expected none", rsp_rdata_o[127:64]);
        end else chk("rsp1_data", rsp_rdata_o[127:64], q1.pop_front());
      end
    end
  end

  initial begin
    rst_ni = 0; req_valid_i = 0; req_we_i = 0; req_be_i = 0; req_addr_i = 0; req_wdata_i = 0;
    rsp_ready_i = 2'b11;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_csb", sram_csb_o, 1);
    chk("rst_web", sram_web_o, 1);
    chk("rst_wmask", sram_wmask_o, 0);
    chk("rst_addr", sram_addr_o, 0);
    chk("rst_spare", sram_spare_wen_o, 0);
    @(negedge clk_i); rst_ni = 1;
    // write then read back, latency 2
    @(negedge clk_i); rq(0, 1, 1, 8'hFF, 9'h005, D0); #1;
    chk("wr_ready", req_ready_o, 2'b01);
    chk("wr_csb", sram_csb_o, 0);
    chk("wr_web", sram_web_o, 0);
    chk("wr_mask", sram_wmask_o, 8'hFF);
    chk("wr_addr", sram_addr_o, 9'h005);
    chk("wr_din", sram_din_o, D0);
    @(negedge clk_i); rq(0, 1, 0, 8'h00, 9'h005, 0); #1;
    chk("rd_ready", req_ready_o, 2'b01);
    chk("rd_csb", sram_csb_o, 0);
    chk("rd_web", sram_web_o, 1);
    chk("rd_mask", sram_wmask_o, 8'hFF);
    q0.push_back(D0);
    @(negedge clk_i); rq(0, 0, 0, 0, 0, 0); #1;
    chk("rd_lat1_valid", rsp_valid_o, 2'b00);
    @(negedge clk_i); #1;
    chk("rd_lat2_valid", rsp_valid_o, 2'b01);
    // round-robin alternation
    @(negedge clk_i); rq(1, 1, 1, 8'hFF, 9'h010, D1); #1;
    chk("wr1_ready", req_ready_o, 2'b10);
    @(negedge clk_i); rq(1, 1, 0, 0, 9'h010, 0); rq(0, 1, 0, 0, 9'h005, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_gnt", req_ready_o, k[0] ? 2'b10 : 2'b01);
      if (k[0]) q1.push_back(D1); else q0.push_back(D0);
`ifdef SRAM_ARB_PERF_EN
      chk("perf_conflict", perf_conflict_o, k);
`endif
      @(negedge clk_i);
    end
    // partial byte-mask write over a zeroed word
    rq(1, 0, 0, 0, 0, 0); rq(0, 1, 1, 8'hFF, 9'h020, 64'h0); #1;
    chk("clr_ready", req_ready_o, 2'b01);
    @(negedge clk_i); rq(0, 1, 1, 8'h0F, 9'h020, '1); #1;
    chk("bm_mask", sram_wmask_o, 8'h0F);
    @(negedge clk_i); rq(0, 1, 0, 0, 9'h020, 0); #1;
    chk("bm_rd_ready", req_ready_o, 2'b01);
    q0.push_back(D2);
    @(negedge clk_i); rq(0, 0, 0, 0, 0, 0);
    // backpressure on requester 1
    @(negedge clk_i); rsp_ready_i = 2'b01; rq(1, 1, 0, 0, 9'h010, 0); #1;
    chk("bp_gnt1", req_ready_o, 2'b10);
    q1.push_back(D1);
    @(negedge clk_i); rq(0, 1, 0, 0, 9'h020, 0); #1;
    chk("bp_gnt0a", req_ready_o, 2'b01);
    q0.push_back(D2);
    @(negedge clk_i); rq(0, 1, 0, 0, 9'h005, 0); #1;
    chk("bp_none", req_ready_o, 2'b00);
    chk("bp_valid1", rsp_valid_o[1], 1);
    @(negedge clk_i); #1;
    chk("bp_gnt0b", req_ready_o, 2'b01);
    q0.push_back(D0);
    @(negedge clk_i); rq(0, 0, 0, 0, 0, 0); #1;
    chk("bp_hold", req_ready_o, 2'b00);
    chk("bp_held_data", rsp_rdata_o[127:64], D1);
    @(negedge clk_i); rsp_ready_i = 2'b11; #1;
    chk("bp_release", req_ready_o, 2'b10);
    q1.push_back(D1);
    // zero-mask write is accepted but leaves the word intact
    @(negedge clk_i); rq(1, 0, 0, 0, 0, 0); rq(0, 1, 1, 8'h00, 9'h005, 64'h0); #1;
    chk("zm_ready", req_ready_o, 2'b01);
    chk("zm_csb", sram_csb_o, 1);
    @(negedge clk_i); rq(0, 1, 0, 0, 9'h005, 0); #1;
    chk("zm_rd_ready", req_ready_o, 2'b01);
    q0.push_back(D0);
    @(negedge clk_i); rq(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_i);
    // reset one cycle after a read grant
    rq(1, 1, 0, 0, 9'h010, 0); #1;
    chk("prst_gnt", req_ready_o, 2'b10);
    @(negedge clk_i); rst_ni = 0; rq(0, 1, 0, 0, 9'h005, 0); #1;
    chk("inrst_ready", req_ready_o, 2'b00);
    chk("inrst_csb", sram_csb_o, 1);
    chk("inrst_valid", rsp_valid_o, 2'b00);
    @(negedge clk_i); #1;
    chk("inrst_valid2", rsp_valid_o, 2'b00);
    @(negedge clk_i); rst_ni = 1; #1;
    chk("postrst_gnt0", req_ready_o, 2'b01);
    chk("postrst_valid", rsp_valid_o, 2'b00);
    q0.push_back(D0);
    @(negedge clk_i); #1;
    chk("postrst_gnt1", req_ready_o, 2'b10);
    q1.push_back(D1);
    @(negedge clk_i); rq(0, 0, 0, 0, 0, 0); rq(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk_i);
    #3;
    chk("drain", q0.size() + q1.size(), 0);
`ifdef SRAM_ARB_PERF_EN
    chk("perf_rd", perf_rd_o, 2);
    chk("perf_wr", perf_wr_o, 0);
    chk("perf_conflict_end", perf_conflict_o, 2);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
